// File: rtl/alu_pipe_pkg.sv
// Shared types for the ALU pipeline: opcode encoding and the buffered result payload.
// The payload widths fix the build widths of alu_pipe's DATA_WIDTH and TAG_WIDTH.
package alu_pipe_pkg;

  localparam int ALU_DATA_WIDTH = 8;
  localparam int ALU_TAG_WIDTH  = 4;
  localparam int ALU_FLAG_WIDTH = 3;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SRA  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11
  } alu_op_e;

  // flags = {err, carry, zero}
  typedef struct packed {
    logic [ALU_DATA_WIDTH-1:0] result;
    logic [ALU_TAG_WIDTH-1:0]  tag;
    logic [ALU_FLAG_WIDTH-1:0] flags;
  } alu_res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Result buffer for alu_pipe: DEPTH-entry FIFO with a combinational head read.
// Storage is cleared on reset so the head never presents unknown data.
module alu_res_fifo
  import alu_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T    = alu_res_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the memory is reset deliberately; head is read straight from it
      // and must show zeros, not leftover content, once reset is released.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-cycle ALU feeding a small result FIFO; each result carries the
// caller's tag and {err, carry, zero} flags back out in acceptance order.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int OP_WIDTH   = 4,
  parameter int TAG_WIDTH  = ALU_TAG_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    a,
  input  logic [DATA_WIDTH-1:0]    b,
  input  logic [OP_WIDTH-1:0]      op,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [2:0]               flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH:0]     diff;
  logic [2*DATA_WIDTH-1:0] rol_w;
  logic [2*DATA_WIDTH-1:0] ror_w;
  logic [DATA_WIDTH-1:0]   res_c;
  logic                    carry_c;
  logic                    err_c;
  alu_res_t                entry;
  alu_res_t                head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // The extra MSB of the difference is the unsigned borrow (a < b).
  assign diff  = {1'b0, a} - {1'b0, b};
  assign rol_w = {a, a} << shamt;
  assign ror_w = {a, a} >> shamt;

  // NOTE: every output of this block gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    case (op)
      OP_WIDTH'(OP_ADD):  {carry_c, res_c} = sum;
      OP_WIDTH'(OP_SUB):  {carry_c, res_c} = diff;
      OP_WIDTH'(OP_AND):  res_c = a & b;
      OP_WIDTH'(OP_OR):   res_c = a | b;
      OP_WIDTH'(OP_XOR):  res_c = a ^ b;
      OP_WIDTH'(OP_SHL):  res_c = a << shamt;
      OP_WIDTH'(OP_SHR):  res_c = a >> shamt;
      OP_WIDTH'(OP_SRA):  res_c = $signed(a) >>> shamt;
      OP_WIDTH'(OP_ROL):  res_c = rol_w[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_WIDTH'(OP_ROR):  res_c = ror_w[DATA_WIDTH-1:0];
      OP_WIDTH'(OP_SLT):  res_c = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_WIDTH'(OP_SLTU): res_c = {{(DATA_WIDTH-1){1'b0}}, a < b};
      default:            err_c = 1'b1;
    endcase
  end

  assign entry.result = res_c;
  assign entry.tag    = in_tag;
  assign entry.flags  = {err_c, carry_c, res_c == '0};

  // Readiness comes from the registered fill level only, never from out_ready.
  assign in_ready  = !rst && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_res_fifo #(
    .DEPTH (DEPTH),
    .T     (alu_res_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign result  = head.result;
  assign out_tag = head.tag;
  assign flags   = head.flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a driver queues hand-computed results on each
// accept, and an independent monitor checks every consumed head against them.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int DW    = 8;
  localparam int OW    = 4;
  localparam int TW    = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [OW-1:0] op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [TW-1:0] out_tag;
  logic [2:0]    flags;
  logic [2:0]    count;

  alu_pipe #(
    .DATA_WIDTH (DW),
    .OP_WIDTH   (OW),
    .TAG_WIDTH  (TW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .flags     (flags),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [14:0] sb [$];
  logic [14:0] exp_v;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offer one operation; queue its expected entry on the edge it is accepted.
  task automatic send(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                      input logic [3:0] t_tag, input logic [7:0] t_res, input logic [2:0] t_fl);
    int waited;
    in_valid = 1'b1;
    op       = t_op;
    a        = t_a;
    b        = t_b;
    in_tag   = t_tag;
    @(negedge clk);
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    else           sb.push_back({t_res, t_tag, t_fl});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        exp_v = sb.pop_front();
        check("out_result", 32'(result),  32'(exp_v[14:7]));
        check("out_tag",    32'(out_tag), 32'(exp_v[6:3]));
        check("out_flags",  32'(flags),   32'(exp_v[2:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] held_res;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    in_tag    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("in_ready_during_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_result",    32'(result),    32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_flags",     32'(flags),     32'd0);
    @(posedge clk);
    #1;

    // Single ADD with carry-out, result visible the cycle after acceptance.
    out_ready = 1'b1;
    send(OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 3'b010);
    check("latency_out_valid", 32'(out_valid), 32'd1);

    // Back-to-back stream covering every opcode; one accept per cycle.
    c0 = cyc;
    send(OP_SUB,  8'h05, 8'h05, 4'h1, 8'h00, 3'b001);
    send(OP_SRA,  8'h80, 8'h09, 4'h2, 8'hC0, 3'b000);
    send(OP_ADD,  8'hFF, 8'h01, 4'h3, 8'h00, 3'b011);
    send(OP_SUB,  8'h03, 8'h05, 4'h4, 8'hFE, 3'b010);
    send(OP_AND,  8'hF0, 8'h3C, 4'h5, 8'h30, 3'b000);
    send(OP_OR,   8'h0F, 8'hF0, 4'h6, 8'hFF, 3'b000);
    send(OP_XOR,  8'hAA, 8'hFF, 4'h7, 8'h55, 3'b000);
    send(OP_SHL,  8'h81, 8'h03, 4'h8, 8'h08, 3'b000);
    send(OP_SHL,  8'h3C, 8'h08, 4'h9, 8'h3C, 3'b000);
    send(OP_SHL,  8'h80, 8'h01, 4'hA, 8'h00, 3'b001);
    send(OP_SHR,  8'h81, 8'h0B, 4'hB, 8'h10, 3'b000);
    send(OP_SRA,  8'h7F, 8'h02, 4'hC, 8'h1F, 3'b000);
    send(OP_ROL,  8'h81, 8'h01, 4'hD, 8'h03, 3'b000);
    send(OP_ROL,  8'h5A, 8'h10, 4'hE, 8'h5A, 3'b000);
    send(OP_ROR,  8'h81, 8'h01, 4'hF, 8'hC0, 3'b000);
    send(OP_ROR,  8'h5A, 8'h00, 4'h0, 8'h5A, 3'b000);
    send(OP_SLT,  8'h80, 8'h01, 4'h1, 8'h01, 3'b000);
    send(OP_SLT,  8'h01, 8'h80, 4'h2, 8'h00, 3'b001);
    send(OP_SLTU, 8'h80, 8'h01, 4'h3, 8'h00, 3'b001);
    send(OP_SLTU, 8'h01, 8'h80, 4'h4, 8'h01, 3'b000);
    send(4'd12,   8'h55, 8'hAA, 4'h5, 8'h00, 3'b101);
    send(4'd13,   8'h12, 8'h34, 4'h6, 8'h00, 3'b101);
    send(4'd15,   8'hFF, 8'hFF, 4'h7, 8'h00, 3'b101);
    check("throughput_cycles", 32'(cyc - c0), 32'd23);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drained_count", 32'(count), 32'd0);

    // Fill with the consumer stalled; the fifth offer must wait.
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 4'd4, 8'h03, 3'b000);
    send(OP_SUB, 8'h10, 8'h01, 4'd5, 8'h0F, 3'b000);
    send(OP_XOR, 8'h33, 8'h33, 4'd6, 8'h00, 3'b001);
    send(OP_OR,  8'h40, 8'h04, 4'd7, 8'h44, 3'b000);
    in_valid = 1'b1;
    op       = OP_AND;
    a        = 8'hFF;
    b        = 8'h0F;
    in_tag   = 4'd8;
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count",    32'(count),    32'd4);
    check("full_head_res", 32'(result),   32'h03);
    check("full_head_tag", 32'(out_tag),  32'd4);
    held_res = result;
    repeat (3) @(negedge clk);
    check("stall_head_stable", 32'(result),    32'(held_res));
    check("stall_out_valid",   32'(out_valid), 32'd1);
    check("stall_count",       32'(count),     32'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("no_accept_when_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("consume_only_count", 32'(count), 32'd3);
    @(negedge clk);
    check("ready_after_consume", 32'(in_ready), 32'd1);
    sb.push_back({8'h0F, 4'd8, 3'b000});
    @(posedge clk);
    #1;
    check("accept_and_consume_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("drained_after_full", 32'(count), 32'd0);

    // Reset with three results buffered and an operation on offer.
    out_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h01, 4'd9,  8'h02, 3'b000);
    send(OP_ADD, 8'h02, 8'h01, 4'd10, 8'h03, 3'b000);
    send(OP_ADD, 8'h03, 8'h01, 4'd11, 8'h04, 3'b000);
    check("count_before_rst", 32'(count), 32'd3);
    rst      = 1'b1;
    op       = OP_ADD;
    a        = 8'h77;
    b        = 8'h11;
    in_tag   = 4'd12;
    sb.delete();
    @(posedge clk);
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_count",     32'(count),     32'd0);
    check("rst_mid_in_ready",  32'(in_ready),  32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(OP_ROL, 8'h81, 8'h01, 4'd13, 8'h03, 3'b000);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("final_out_valid", 32'(out_valid), 32'd0);
    check("sb_drained",      32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
